branch_predictor: RTL

- IF-stage next-PC predictor for the 5-stage RV32I pipeline.
- Predicts the next fetch PC: a direct-mapped BTB supplies targets, a BHT of 2-bit saturating counters supplies conditional-branch direction.
- Compares the EX-stage jump resolution (`is_jump`/`taken_pc`) with the prediction carried down the pipe; raises `mispredict` with the corrected PC.
- Updates its tables and performance counters on the following clock edge.

---
 rtl/bp_pkg.sv | 37 +++
 rtl/bp_btb.sv | 38 +++
 rtl/branch_predictor.sv | 110 +++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared types and defaults for the next-PC branch predictor.
// Holds counter encodings, BTB entry layout and saturating-update helpers.
package bp_pkg;

    localparam int BP_IDX_BITS  = 5;
    localparam int BP_HIST_BITS = 5;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_ctr_e;

    // tag holds pc >> (IDX_BITS+2), zero-extended so the layout is index-width independent
    typedef struct packed {
        logic        valid;
        logic [31:0] tag;
        logic [31:0] target;
        logic        uncond;
    } btb_entry_t;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken && ctr != ST)
            nxt = ctr + 2'd1;
        else if (!taken && ctr != SNT)
            nxt = ctr - 2'd1;
        return nxt;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] val);
        return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: one combinational read port, one
// synchronous write / tag-qualified invalidate port.
module bp_btb
    import bp_pkg::*;
#(
    parameter int IDX_BITS = BP_IDX_BITS
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [IDX_BITS-1:0] i_rd_idx,
    output btb_entry_t          o_rd_entry,
    input  logic                i_wr_en,
    input  logic                i_inv_en,
    input  logic [IDX_BITS-1:0] i_wr_idx,
    input  logic [31:0]         i_wr_tag,
    input  logic [31:0]         i_wr_target,
    input  logic                i_wr_uncond
);

    localparam int DEPTH = 1 << IDX_BITS;

    btb_entry_t r_mem [DEPTH];

    assign o_rd_entry = r_mem[i_rd_idx];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else if (i_wr_en) begin
            r_mem[i_wr_idx] <= '{valid: 1'b1, tag: i_wr_tag, target: i_wr_target, uncond: i_wr_uncond};
        end else if (i_inv_en && r_mem[i_wr_idx].valid && (r_mem[i_wr_idx].tag == i_wr_tag)) begin
            // only drop the entry if it really belongs to this non-control PC
            r_mem[i_wr_idx].valid <= 1'b0;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// IF-stage next-PC predictor (BTB + 2-bit BHT) with EX-stage mispredict detection.
// Define BP_GSHARE_EN for gshare BHT indexing; the default build is bimodal.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int IDX_BITS  = BP_IDX_BITS,
    parameter int HIST_BITS = BP_HIST_BITS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IF_current_pc,
    output logic [31:0] predicted_pc,
    output logic        IF_pred_taken,
    input  logic        ID_EX_valid,
    input  logic        ID_EX_is_jal,
    input  logic        ID_EX_is_jalr,
    input  logic        ID_EX_branch,
    input  logic [31:0] ID_EX_current_pc,
    input  logic [31:0] ID_EX_pred_pc,
    input  logic        is_jump,
    input  logic [31:0] taken_pc,
    output logic        mispredict,
    output logic [31:0] correct_pc,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    localparam int DEPTH = 1 << IDX_BITS;

    if (HIST_BITS > IDX_BITS || HIST_BITS < 2) begin : g_hist_check
        $error("branch_predictor: HIST_BITS must be in 2..IDX_BITS");
    end

    logic [IDX_BITS-1:0] w_if_idx, w_ex_idx, w_if_bht_idx, w_ex_bht_idx;
    logic [31:0]         w_if_tag, w_ex_tag, w_actual_pc;
    logic                w_ctrl, w_hit;
    btb_entry_t          w_if_entry;
    logic [1:0]          r_bht [DEPTH];
    logic [31:0]         r_branch_count, r_mispredict_count;

    assign w_if_idx = IF_current_pc[IDX_BITS+1:2];
    assign w_ex_idx = ID_EX_current_pc[IDX_BITS+1:2];
    assign w_if_tag = IF_current_pc >> (IDX_BITS + 2);
    assign w_ex_tag = ID_EX_current_pc >> (IDX_BITS + 2);

`ifdef BP_GSHARE_EN
    logic [HIST_BITS-1:0] r_ghr;

    assign w_if_bht_idx = w_if_idx ^ IDX_BITS'(r_ghr);
    assign w_ex_bht_idx = w_ex_idx ^ IDX_BITS'(r_ghr);

    // non-speculative history: only resolved branches shift in
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_ghr <= '0;
        else if (ID_EX_valid && ID_EX_branch)
            r_ghr <= {r_ghr[HIST_BITS-2:0], is_jump};
    end
`else
    assign w_if_bht_idx = w_if_idx;
    assign w_ex_bht_idx = w_ex_idx;
`endif

    bp_btb #(.IDX_BITS(IDX_BITS)) u_btb (
        .i_clk       (clk),
        .i_rst       (reset),
        .i_rd_idx    (w_if_idx),
        .o_rd_entry  (w_if_entry),
        .i_wr_en     (ID_EX_valid && w_ctrl && is_jump),
        .i_inv_en    (ID_EX_valid && !w_ctrl),
        .i_wr_idx    (w_ex_idx),
        .i_wr_tag    (w_ex_tag),
        .i_wr_target (taken_pc),
        .i_wr_uncond (ID_EX_is_jal || ID_EX_is_jalr)
    );

    assign w_hit         = w_if_entry.valid && (w_if_entry.tag == w_if_tag);
    assign IF_pred_taken = w_hit && (w_if_entry.uncond || r_bht[w_if_bht_idx][1]);
    assign predicted_pc  = IF_pred_taken ? w_if_entry.target : IF_current_pc + 32'd4;

    assign w_ctrl      = ID_EX_is_jal || ID_EX_is_jalr || ID_EX_branch;
    assign w_actual_pc = is_jump ? taken_pc : ID_EX_current_pc + 32'd4;
    assign mispredict  = ID_EX_valid && (w_actual_pc != ID_EX_pred_pc);
    assign correct_pc  = ID_EX_valid ? w_actual_pc : 32'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                r_bht[i] <= WNT;
        end else if (ID_EX_valid && ID_EX_branch) begin
            r_bht[w_ex_bht_idx] <= ctr_next(r_bht[w_ex_bht_idx], is_jump);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else if (ID_EX_valid) begin
            if (w_ctrl)
                r_branch_count <= sat_inc32(r_branch_count);
            if (mispredict)
                r_mispredict_count <= sat_inc32(r_mispredict_count);
        end
    end

    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;

endmodule
